apb_reg_bank: RTL



---
 rtl/apb_reg_pkg.sv | 37 +++
 rtl/apb_slave_fsm.sv | 77 +++++++
 rtl/apb_reg_bank.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register bank: FSM state codes,
// register index map and the address-window decode helper.
package apb_reg_pkg;

   // Handshake FSM state codes kept as plain constants for older tools
   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE = 2'd0;
   localparam fsm_state_t ST_WAIT = 2'd1;
   localparam fsm_state_t ST_ACC  = 2'd2;

   // Fixed register positions; everything above the LED block is scratch
   localparam int IDX_ID     = 0;
   localparam int IDX_CTRL   = 1;
   localparam int IDX_STATUS = 2;
   localparam int IDX_LED0   = 3;

   typedef struct packed {
      logic        in_win;
      logic        aligned;
      logic [15:0] idx;
   } decode_t;

   // Splits a byte address into window hit, word alignment and word index.
   // aw is log2 of the register count, so the window spans 4 << aw bytes.
   function automatic decode_t addr_decode(input logic [15:0] addr,
                                           input logic [15:0] base,
                                           input int          aw);
      decode_t     d;
      logic [15:0] mask;
      mask      = 16'((32'd1 << aw) - 32'd1);
      d.in_win  = ((addr >> (aw + 2)) == (base >> (aw + 2)));
      d.aligned = (addr[1:0] == 2'b00);
      d.idx     = (addr >> 2) & mask;
      return d;
   endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 slave handshake: IDLE/WAIT/ACC sequencing, programmable wait
// counter and the registered pready pulse. Emits strobes so the register
// array knows when to capture the setup address and when to commit.
module apb_slave_fsm
   import apb_reg_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic psel,
   input  logic penable,
   output logic setup_stb,
   output logic acc_entry,
   output logic commit_stb,
   output logic pready
);

   localparam logic [3:0] WCNT_LOAD = 4'(WAIT_STATES);

   fsm_state_t state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       pready_q, pready_d;

   // Next-state and wait-counter logic; a dropped psel in WAIT abandons the transfer
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      setup_stb = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               setup_stb = 1'b1;
               wcnt_d    = WCNT_LOAD;
               state_d   = (WAIT_STATES == 0) ? ST_ACC : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               state_d = ST_IDLE;
               wcnt_d  = 4'd0;
            end else if (penable) begin
               if (wcnt_q == 4'd1) begin
                  state_d = ST_ACC;
               end
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_ACC: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = 4'd0;
         end
      endcase
      acc_entry  = (state_d == ST_ACC);
      commit_stb = (state_q == ST_ACC);
      pready_d   = acc_entry;
   end

   // State, counter and pready registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= 4'd0;
         pready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         pready_q <= pready_d;
      end
   end

   assign pready = pready_q;

endmodule

// File: rtl/apb_reg_bank.sv
// APB3 slave register bank: read-only ID, CTRL with irq mask, W1C STATUS
// fed by level events, RGB LED registers and scratch words, with byte
// strobes, registered read response and a registered maskable interrupt.
module apb_reg_bank
   import apb_reg_pkg::*;
#(
   parameter logic [15:0]   BASE_ADDR     = 16'h0100,
   parameter int            NUM_REGS      = 8,
   parameter int            DW            = 32,
   parameter int            NUM_EVT       = 4,
   parameter int            NUM_LED       = 2,
   parameter int            WAIT_STATES   = 0,
   parameter logic [DW-1:0] ID_VALUE      = 32'hA5B0_0100,
   parameter logic [DW-1:0] RDATA_DEFAULT = 32'h1234_5678
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          paddr,
   input  logic                 psel,
   input  logic                 penable,
   input  logic                 pwrite,
   input  logic [DW-1:0]        pwdata,
   input  logic [DW/8-1:0]      pstrb,
   output logic [DW-1:0]        prdata,
   output logic                 pready,
   output logic                 pslverr,
   input  logic [NUM_EVT-1:0]   hw_evt,
   output logic                 irq,
   output logic [3*NUM_LED-1:0] led_rgb
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int NB = DW / 8;

   logic setup_stb;
   logic acc_entry;
   logic commit_stb;

   logic [15:0]        addr_q, addr_d;
   logic               pwrite_q, pwrite_d;
   logic [DW-1:0]      prdata_q, prdata_d;
   logic               pslverr_q, pslverr_d;
   logic [NUM_EVT-1:0] status_q, status_d;
   logic               irq_q, irq_d;
   logic [DW-1:0]      rw_q [NUM_REGS];
   logic [DW-1:0]      rw_d [NUM_REGS];

   decode_t            dec;
   logic [AW-1:0]      rd_idx;
   logic [AW-1:0]      wr_idx;
   logic               acc_err;
   logic [DW-1:0]      rd_val;
   logic [DW-1:0]      wmask;
   logic [DW-1:0]      wdata_m;
   logic               commit;
   logic [NUM_EVT-1:0] status_clr;

   apb_slave_fsm #(
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .psel       (psel),
      .penable    (penable),
      .setup_stb  (setup_stb),
      .acc_entry  (acc_entry),
      .commit_stb (commit_stb),
      .pready     (pready)
   );

   // Hold the setup-phase address and direction; pass them straight through on the setup cycle itself
   always_comb begin
      addr_d   = setup_stb ? paddr  : addr_q;
      pwrite_d = setup_stb ? pwrite : pwrite_q;
   end

   // Decode the held address and build the response that is registered on entry to ACC
   always_comb begin
      dec     = addr_decode(addr_d, BASE_ADDR, AW);
      rd_idx  = dec.idx[AW-1:0];
      acc_err = !dec.in_win || !dec.aligned ||
                (pwrite_d && (rd_idx == AW'(IDX_ID)));

      rd_val = rw_q[rd_idx];
      if (rd_idx == AW'(IDX_ID)) begin
         rd_val = ID_VALUE;
      end else if (rd_idx == AW'(IDX_STATUS)) begin
         rd_val                = '0;
         rd_val[NUM_EVT-1:0]   = status_q;
      end

      prdata_d  = '0;
      pslverr_d = 1'b0;
      if (acc_entry) begin
         pslverr_d = acc_err;
         if (!pwrite_d) begin
            if (!dec.in_win) begin
               prdata_d = RDATA_DEFAULT;
            end else if (!acc_err) begin
               prdata_d = rd_val;
            end
         end
      end
   end

   // Byte-strobed write commit at the end of ACC, plus W1C/event update of STATUS and irq
   always_comb begin
      for (int k = 0; k < NB; k++) begin
         wmask[8*k +: 8] = {8{pstrb[k]}};
      end
      wdata_m = pwdata & wmask;
      wr_idx  = addr_q[AW+1:2];
      commit  = commit_stb && pwrite_q && !pslverr_q;

      rw_d = rw_q;
      if (commit && (wr_idx != AW'(IDX_ID)) && (wr_idx != AW'(IDX_STATUS))) begin
         rw_d[wr_idx] = (rw_q[wr_idx] & ~wmask) | wdata_m;
      end

      status_clr = '0;
      if (commit && (wr_idx == AW'(IDX_STATUS))) begin
         status_clr = wdata_m[NUM_EVT-1:0];
      end
      status_d = (status_q & ~status_clr) | hw_evt;

      irq_d = |(status_q & rw_q[IDX_CTRL][NUM_EVT-1:0]);
   end

   // All bank state with synchronous reset; ID is a constant and needs no storage
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         pwrite_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         status_q  <= '0;
         irq_q     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            rw_q[i] <= '0;
         end
      end else begin
         addr_q    <= addr_d;
         pwrite_q  <= pwrite_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         status_q  <= status_d;
         irq_q     <= irq_d;
         rw_q      <= rw_d;
      end
   end

   genvar n;
   for (n = 0; n < NUM_LED; n++) begin : g_led
      assign led_rgb[3*n +: 3] = rw_q[IDX_LED0 + n][2:0];
   end

   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;
   assign irq     = irq_q;

   logic unused_bits;
   assign unused_bits = ^{dec.idx, wdata_m};

endmodule
